bist_ram: RTL
=============

BIST_RAM -- requirements
Module: bist_ram

Interface
REQ-001 SHALL have parameter A_WIDTH, default 4, meaning address bus width in bits.
REQ-002 SHALL have parameter WIDTH, default 4, meaning data word width in bits.
REQ-003 SHALL have parameter DEPTH, default 16, meaning number of implemented words, legal range 1..2^A_WIDTH.
REQ-004 SHALL have parameter INIT_VALUE, default 0, meaning WIDTH-bit word written to every location during initialisation.
REQ-005 SHALL have one clock; reset is synchronous and active-high.
REQ-006 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-008 SHALL have port read, input, 1 bit, read request.
REQ-009 SHALL have port write, input, 1 bit, write request.
REQ-010 SHALL have port address, input, A_WIDTH bits, word address.
REQ-011 SHALL have port data_in, input, WIDTH bits, write data.
REQ-012 SHALL have port fault_en, input, 1 bit, enables stuck-at fault injection on the read path.
REQ-013 SHALL have port fault_addr, input, A_WIDTH bits, faulty word address.
REQ-014 SHALL have port fault_bit, input, max(1,clog2(WIDTH)) bits, faulty bit index.
REQ-015 SHALL have port fault_val, input, 1 bit, stuck-at value.
REQ-016 SHALL have port data_out, output, WIDTH bits, registered read data.
REQ-017 SHALL have port rd_valid, output, 1 bit, one-cycle pulse marking new data_out.
REQ-018 SHALL have port busy, output, 1 bit, high while initialisation runs.
REQ-019 SHALL have port err_addr, output, 1 bit, one-cycle pulse: request to address >= DEPTH.
REQ-020 SHALL have port err_collision, output, 1 bit, one-cycle pulse: read and write asserted together.

Function
REQ-021 SHALL implement a two-state FSM: INIT and IDLE; rst forces INIT with init counter = 0.
REQ-022 In INIT, each cycle SHALL write INIT_VALUE to mem[counter] and increment counter; after writing location DEPTH-1 it SHALL go to IDLE.
REQ-023 busy SHALL be high in INIT, so busy is high for exactly DEPTH cycles after the cycle in which rst was sampled high, then low.
REQ-024 Requests (read/write) while busy SHALL be ignored: no memory access, no rd_valid, no error pulses.
REQ-025 In IDLE, write=1, read=0, address < DEPTH SHALL store data_in at mem[address] at that edge.
REQ-026 In IDLE, read=1, write=0, address < DEPTH SHALL load data_out with mem[address] and assert rd_valid for one cycle, both visible the cycle after the request (latency 1).
REQ-027 Read data SHALL reflect the memory contents before any write in the same cycle; read-after-write to the same address on consecutive cycles SHALL return the new data.
REQ-028 If fault_en=1 and the read address equals fault_addr, bit fault_bit of data_out SHALL equal fault_val; stored contents SHALL be unmodified; fault_bit >= WIDTH SHALL have no effect.
REQ-029 read=1 and write=1 in IDLE SHALL perform no access, no rd_valid, and pulse err_collision the next cycle; err_addr SHALL not pulse in that case.
REQ-030 A single read or write with address >= DEPTH in IDLE SHALL perform no access, no rd_valid, and pulse err_addr the next cycle.
REQ-031 data_out SHALL hold its value in every cycle without a valid read.
REQ-032 Neither read nor write in IDLE SHALL change any state or output except clearing pulses.

Reset
REQ-033 rst SHALL set data_out=0, rd_valid=0, err_addr=0, err_collision=0, busy=1, FSM=INIT, counter=0.
REQ-034 rst asserted mid-initialisation or mid-operation SHALL restart initialisation from location 0; all prior contents are overwritten with INIT_VALUE.

Verification
REQ-035 Default params: pulse rst 1 cycle -> busy high exactly 16 cycles; then reads of addresses 0..15 each return 0 with rd_valid pulse one cycle after request.
REQ-036 Write 4'hA to address 3, next cycle read address 3 -> data_out=4'hA, rd_valid=1 one cycle later; data_out holds 4'hA in following idle cycles.
REQ-037 DEPTH=12: read address 13 -> err_addr pulses once, rd_valid stays 0, data_out unchanged.
REQ-038 read=write=1, address 5, data_in 4'hF -> err_collision pulses; subsequent read of address 5 returns prior contents, not 4'hF.
REQ-039 mem[7]=4'b0000, fault_en=1, fault_addr=7, fault_bit=2, fault_val=1, read 7 -> data_out=4'b0100; fault_en=0, read 7 -> 4'b0000.
REQ-040 Write 4'h5 to address 2, assert rst at init counter 6 of second init, read address 2 after busy falls -> data_out=INIT_VALUE.

Source files
------------

// File: rtl/bist_ram.sv
// Word-addressed RAM that clears itself to INIT_VALUE after every reset and
// offers stuck-at fault injection on the read path for BIST experiments.
module bist_ram #(
  parameter int                A_WIDTH    = 4,
  parameter int                WIDTH      = 4,
  parameter int                DEPTH      = 16,
  parameter logic [WIDTH-1:0]  INIT_VALUE = '0
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          read,
  input  logic                                          write,
  input  logic [A_WIDTH-1:0]                            address,
  input  logic [WIDTH-1:0]                              data_in,
  input  logic                                          fault_en,
  input  logic [A_WIDTH-1:0]                            fault_addr,
  input  logic [((WIDTH > 1) ? $clog2(WIDTH) : 1)-1:0]  fault_bit,
  input  logic                                          fault_val,
  output logic [WIDTH-1:0]                              data_out,
  output logic                                          rd_valid,
  output logic                                          busy,
  output logic                                          err_addr,
  output logic                                          err_collision
);

  localparam int FB_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [A_WIDTH:0]   DEPTH_W  = (A_WIDTH + 1)'(DEPTH);
  localparam logic [A_WIDTH-1:0] LAST_LOC = A_WIDTH'(DEPTH - 1);
  localparam logic [FB_W:0]      WIDTH_FB = (FB_W + 1)'(WIDTH);

  typedef enum logic {INIT, IDLE} state_t;

  state_t               state;
  state_t               next_state;
  logic [A_WIDTH-1:0]   counter;
  logic [WIDTH-1:0]     mem [DEPTH];
  logic                 in_range;
  logic                 do_read;
  logic                 do_write;
  logic                 collision;
  logic                 addr_err;
  logic [WIDTH-1:0]     rd_word;

  always_ff @(posedge clk) begin
    if (rst) state <= INIT;
    else     state <= next_state;
  end

  // Requests are only decoded in IDLE, so anything arriving during init is dropped.
  always_comb begin
    next_state = state;
    busy       = 1'b0;
    do_read    = 1'b0;
    do_write   = 1'b0;
    collision  = 1'b0;
    addr_err   = 1'b0;
    in_range   = {1'b0, address} < DEPTH_W;
    case (state)
      INIT: begin
        busy = 1'b1;
        if (counter == LAST_LOC) next_state = IDLE;
      end
      IDLE: begin
        collision = read && write;
        do_read   = read && !write && in_range;
        do_write  = write && !read && in_range;
        addr_err  = (read ^ write) && !in_range;
      end
      default: next_state = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)                counter <= '0;
    else if (state == INIT) counter <= counter + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == INIT) mem[counter] <= INIT_VALUE;
      else if (do_write) mem[address] <= data_in;
    end
  end

  // Fault overlay touches only the word being returned, never the array.
  always_comb begin
    rd_word = mem[address];
    if (fault_en && (address == fault_addr) && ({1'b0, fault_bit} < WIDTH_FB))
      rd_word[fault_bit] = fault_val;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_out      <= '0;
      rd_valid      <= 1'b0;
      err_addr      <= 1'b0;
      err_collision <= 1'b0;
    end else begin
      rd_valid      <= do_read;
      err_addr      <= addr_err;
      err_collision <= collision;
      if (do_read) data_out <= rd_word;
    end
  end

endmodule
